vdp_vram_arb: RTL

- Two-port arbiter/sequencer for the single VDP VRAM SRAM controller.
- Requesters: display fetch FSM (reads only, priority) and CPU VRAM port (reads/writes).
- Serialises their requests onto one req/ack channel toward the SRAM controller.
- A starvation guard bounds CPU wait while the display fetch FSM saturates VRAM.

---
 rtl/vdp_vram_arb.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/vdp_vram_arb.sv
// ---------------------------------------------------------------------------
// vdp_vram_arb
//
// Purpose:
//    Arbitrates the display fetch FSM and the CPU VRAM port onto the single
//    req/ack channel of the VRAM SRAM controller. The display has priority;
//    a wait counter lets the CPU beat a pending display request once it has
//    waited STARVE_LIMIT cycles, so CPU latency stays bounded while the
//    display saturates VRAM.
//
// Ports:
//    clk40m, rst_n            clock, synchronous active-low reset
//    vid_req/addr             display read request (held until vid_ack)
//    vid_ack/rdata            display completion pulse and read data
//    cpu_req/wr/addr/wdata    CPU read/write request (held until cpu_ack)
//    cpu_ack/rdata            CPU completion pulse and read data
//    mem_req/wr/addr/wdata    registered request toward the SRAM controller
//    mem_ack/rdata            SRAM controller completion and read data
//    cpu_forced               pulse in the first CPU_BUSY cycle of a grant
//                             that preempted a pending display request
//    dbg_state                current FSM state (IDLE=0, VID_BUSY=1,
//                             CPU_BUSY=2, DONE=3)
//    dbg_starve_cnt           current CPU wait counter
//
// Handshake: a requester raises req with stable addr/wr/wdata and holds it
// until it sees its one-cycle ack, then drops req on the following edge.
// mem_req stays high until mem_ack; mem_ack outside a BUSY state is ignored.
// ---------------------------------------------------------------------------
module vdp_vram_arb #(
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic        clk40m,
   input  logic        rst_n,
   input  logic        vid_req,
   input  logic [13:0] vid_addr,
   output logic        vid_ack,
   output logic [7:0]  vid_rdata,
   input  logic        cpu_req,
   input  logic        cpu_wr,
   input  logic [13:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic        cpu_ack,
   output logic [7:0]  cpu_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [13:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic        mem_ack,
   input  logic [7:0]  mem_rdata,
   output logic        cpu_forced,
   output logic [1:0]  dbg_state,
   output logic [3:0]  dbg_starve_cnt
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      VID_BUSY = 2'd1,
      CPU_BUSY = 2'd2,
      DONE     = 2'd3
   } state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t      r_state;
   state_t      w_next_state;
   logic        w_grant_vid;
   logic        w_grant_cpu;
   logic        w_forced;

   logic [3:0]  r_starve_cnt;
   logic        r_mem_req;
   logic        r_mem_wr;
   logic [13:0] r_mem_addr;
   logic [7:0]  r_mem_wdata;
   logic        r_vid_ack;
   logic        r_cpu_ack;
   logic [7:0]  r_vid_rdata;
   logic [7:0]  r_cpu_rdata;
   logic        r_cpu_forced;

   // Next-state and grant decision
   always_comb begin
      w_next_state = r_state;
      w_grant_vid  = 1'b0;
      w_grant_cpu  = 1'b0;
      case (r_state)
         IDLE: begin
            if (vid_req && cpu_req) begin
               if (r_starve_cnt >= LIMIT) w_grant_cpu = 1'b1;
               else                       w_grant_vid = 1'b1;
            end else if (vid_req) begin
               w_grant_vid = 1'b1;
            end else if (cpu_req) begin
               w_grant_cpu = 1'b1;
            end
            if (w_grant_vid)      w_next_state = VID_BUSY;
            else if (w_grant_cpu) w_next_state = CPU_BUSY;
         end
         VID_BUSY, CPU_BUSY: begin
            if (mem_ack) w_next_state = DONE;
         end
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
      // A CPU grant with the display still asking means the guard fired
      w_forced = w_grant_cpu && vid_req;
   end

   always_ff @(posedge clk40m) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   // Registered datapath: mem_* captured on the grant edge, acks and read
   // data captured on the edge that finishes a BUSY state.
   always_ff @(posedge clk40m) begin
      if (!rst_n) begin
         r_starve_cnt <= 4'd0;
         r_mem_req    <= 1'b0;
         r_mem_wr     <= 1'b0;
         r_mem_addr   <= 14'd0;
         r_mem_wdata  <= 8'd0;
         r_vid_ack    <= 1'b0;
         r_cpu_ack    <= 1'b0;
         r_vid_rdata  <= 8'd0;
         r_cpu_rdata  <= 8'd0;
         r_cpu_forced <= 1'b0;
      end else begin
         r_vid_ack    <= 1'b0;
         r_cpu_ack    <= 1'b0;
         r_cpu_forced <= w_forced;

         if (w_grant_vid) begin
            r_mem_req  <= 1'b1;
            r_mem_wr   <= 1'b0;
            r_mem_addr <= vid_addr;
         end
         if (w_grant_cpu) begin
            r_mem_req   <= 1'b1;
            r_mem_wr    <= cpu_wr;
            r_mem_addr  <= cpu_addr;
            r_mem_wdata <= cpu_wdata;
         end

         if (r_state == VID_BUSY && mem_ack) begin
            r_mem_req   <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_vid_ack   <= 1'b1;
            r_vid_rdata <= mem_rdata;
         end
         if (r_state == CPU_BUSY && mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_cpu_ack <= 1'b1;
            // r_mem_wr still holds the direction of the finishing access
            if (!r_mem_wr) r_cpu_rdata <= mem_rdata;
         end

         // CPU wait counter: counts only while the CPU is actually losing
         // time (IDLE or serving the display); DONE holds it.
         if (w_grant_cpu) begin
            r_starve_cnt <= 4'd0;
         end else if (cpu_req && (r_state == IDLE || r_state == VID_BUSY)
                      && r_starve_cnt != 4'hF) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
         end
      end
   end

   assign vid_ack        = r_vid_ack;
   assign vid_rdata      = r_vid_rdata;
   assign cpu_ack        = r_cpu_ack;
   assign cpu_rdata      = r_cpu_rdata;
   assign mem_req        = r_mem_req;
   assign mem_wr         = r_mem_wr;
   assign mem_addr       = r_mem_addr;
   assign mem_wdata      = r_mem_wdata;
   assign cpu_forced     = r_cpu_forced;
   assign dbg_state      = r_state;
   assign dbg_starve_cnt = r_starve_cnt;

endmodule
